// File: rtl/sample_mul_pkg.sv
// Shared constants and saturation-bound helpers for the sample-datapath multiplier family.
package sample_mul_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Bounds are returned 64 bits wide so callers can compare any narrower sign-extended value.
    function automatic logic signed [63:0] satMax(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] satMin(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/sample_mul_rndsat.sv
// Combinational fixed-point scaler: optional half-up bias, arithmetic shift, then wrap or clamp.
module sample_mul_rndsat
    import sample_mul_pkg::*;
#(
    parameter int IN_WIDTH   = 22,
    parameter int DOUT_WIDTH = 11,
    parameter int FRAC_SHIFT = 0,
    parameter int ROUND_MODE = ROUND_TRUNC,
    parameter int SAT_EN     = SAT_WRAP
) (
    input  logic signed [IN_WIDTH-1:0]   prod_i,
    output logic signed [DOUT_WIDTH-1:0] dout_o,
    output logic                         ovf_o
);

    localparam int BIAS_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic signed [IN_WIDTH:0] BIAS =
        (ROUND_MODE == ROUND_HALF_UP && FRAC_SHIFT > 0) ?
        ((IN_WIDTH + 1)'(1) << BIAS_POS) : (IN_WIDTH + 1)'(0);

    // One guard bit so adding the bias to the most positive product cannot wrap.
    logic signed [IN_WIDTH:0]     biased;
    logic signed [IN_WIDTH:0]     shifted;
    logic signed [63:0]           shiftedL;
    logic signed [DOUT_WIDTH-1:0] wrapped;
    logic signed [63:0]           wrapL;

    assign biased   = {prod_i[IN_WIDTH-1], prod_i} + BIAS;
    assign shifted  = biased >>> FRAC_SHIFT;
    assign shiftedL = 64'(shifted);
    assign wrapped  = shiftedL[DOUT_WIDTH-1:0];
    assign wrapL    = 64'(wrapped);

    always_comb begin
        dout_o = wrapped;
        ovf_o  = (wrapL != shiftedL);
        if (SAT_EN == SAT_CLAMP) begin
            if (shiftedL > satMax(DOUT_WIDTH)) begin
                dout_o = DOUT_WIDTH'(satMax(DOUT_WIDTH));
                ovf_o  = 1'b1;
            end else if (shiftedL < satMin(DOUT_WIDTH)) begin
                dout_o = DOUT_WIDTH'(satMin(DOUT_WIDTH));
                ovf_o  = 1'b1;
            end else begin
                ovf_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sample_mul_pipe_rs.sv
// Parametrised pipelined signed multiplier with fixed-point scaling, valid tracking and a
// saturating overflow counter; defaults reproduce the legacy 11x11 two-stage multiplier.
module sample_mul_pipe_rs
    import sample_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 11,
    parameter int DIN1_WIDTH = 11,
    parameter int DOUT_WIDTH = 11,
    parameter int NUM_STAGE  = 2,
    parameter int FRAC_SHIFT = 0,
    parameter int ROUND_MODE = ROUND_TRUNC,
    parameter int SAT_EN     = SAT_WRAP,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         cnt_clr,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_valid,
    output logic                         ovf,
    output logic [CNT_WIDTH-1:0]         ovf_cnt
);

    localparam int PW    = DIN0_WIDTH + DIN1_WIDTH;
    localparam int CHAIN = NUM_STAGE - 2;

    logic signed [DIN0_WIDTH-1:0] opA_q;
    logic signed [DIN1_WIDTH-1:0] opB_q;
    logic                         validIn_q;
    logic signed [PW-1:0]         prodComb;
    logic signed [PW-1:0]         prodFinal;
    logic                         validFinal;
    logic signed [DOUT_WIDTH-1:0] rsDout;
    logic                         rsOvf;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic                         ovf_q;
    logic                         validOut_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic [CNT_WIDTH-1:0]         cnt_d;
    logic                         cntInc;

    // Operands load on every ce regardless of valid, as the legacy part did.
    always_ff @(posedge clk) begin
        if (reset) begin
            validIn_q <= 1'b0;
        end else if (ce) begin
            opA_q     <= din0;
            opB_q     <= din1;
            validIn_q <= in_valid;
        end
    end

    assign prodComb = PW'(opA_q) * PW'(opB_q);

    if (CHAIN == 0) begin : g_noChain
        assign prodFinal  = prodComb;
        assign validFinal = validIn_q;
    end else begin : g_chain
        logic signed [PW-1:0] prod_q  [CHAIN];
        logic                 valid_q [CHAIN];

        for (genvar s = 0; s < CHAIN; s++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q[s] <= 1'b0;
                end else if (ce) begin
                    prod_q[s]  <= (s == 0) ? prodComb  : prod_q[(s == 0) ? 0 : s - 1];
                    valid_q[s] <= (s == 0) ? validIn_q : valid_q[(s == 0) ? 0 : s - 1];
                end
            end
        end

        assign prodFinal  = prod_q[CHAIN-1];
        assign validFinal = valid_q[CHAIN-1];
    end

    sample_mul_rndsat #(
        .IN_WIDTH   (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .ROUND_MODE (ROUND_MODE),
        .SAT_EN     (SAT_EN)
    ) u_rndsat (
        .prod_i (prodFinal),
        .dout_o (rsDout),
        .ovf_o  (rsOvf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q     <= '0;
            ovf_q      <= 1'b0;
            validOut_q <= 1'b0;
        end else if (ce) begin
            dout_q     <= rsDout;
            ovf_q      <= rsOvf & validFinal;
            validOut_q <= validFinal;
        end
    end

    // A clear that coincides with a counted beat leaves exactly that beat in the count.
    assign cntInc = ce & validFinal & rsOvf;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = cntInc ? CNT_WIDTH'(1) : '0;
        end else if (cntInc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = validOut_q;
    assign ovf       = ovf_q;
    assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_sample_mul_pipe_rs.sv
// Directed bench: six parameterisations share one stimulus stream; each step checks the
// instance whose behaviour it exercises against hand-computed values.
module tb_sample_mul_pipe_rs;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic inValid;
    logic cntClr;
    logic signed [10:0] din0;
    logic signed [10:0] din1;

    always #5 clk = ~clk;

    logic signed [10:0] defDout, satDout, rndDout, trnDout, deepDout, cntDout;
    logic defValid, satValid, rndValid, trnValid, deepValid, cntValid;
    logic defOvf, satOvf, rndOvf, trnOvf, deepOvf, cntOvf;
    logic [15:0] defCnt, satCnt, rndCnt, trnCnt, deepCnt;
    logic [1:0]  cntCnt;

    int checks   = 0;
    int failures = 0;

    sample_mul_pipe_rs u_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .din0(din0), .din1(din1),
        .cnt_clr(cntClr), .dout(defDout), .out_valid(defValid), .ovf(defOvf), .ovf_cnt(defCnt)
    );

    sample_mul_pipe_rs #(.SAT_EN(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .din0(din0), .din1(din1),
        .cnt_clr(cntClr), .dout(satDout), .out_valid(satValid), .ovf(satOvf), .ovf_cnt(satCnt)
    );

    sample_mul_pipe_rs #(.FRAC_SHIFT(4), .ROUND_MODE(1)) u_rnd (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .din0(din0), .din1(din1),
        .cnt_clr(cntClr), .dout(rndDout), .out_valid(rndValid), .ovf(rndOvf), .ovf_cnt(rndCnt)
    );

    sample_mul_pipe_rs #(.FRAC_SHIFT(4), .ROUND_MODE(0)) u_trn (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .din0(din0), .din1(din1),
        .cnt_clr(cntClr), .dout(trnDout), .out_valid(trnValid), .ovf(trnOvf), .ovf_cnt(trnCnt)
    );

    sample_mul_pipe_rs #(.NUM_STAGE(4)) u_deep (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .din0(din0), .din1(din1),
        .cnt_clr(cntClr), .dout(deepDout), .out_valid(deepValid), .ovf(deepOvf), .ovf_cnt(deepCnt)
    );

    sample_mul_pipe_rs #(.CNT_WIDTH(2)) u_cnt (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .din0(din0), .din1(din1),
        .cnt_clr(cntClr), .dout(cntDout), .out_valid(cntValid), .ovf(cntOvf), .ovf_cnt(cntCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int a, input int b);
        inValid = v;
        din0    = 11'(a);
        din1    = 11'(b);
        tick();
    endtask

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int stallExp[4];
        stallExp = '{6, 9, 12, 15};

        reset = 1'b1; ce = 1'b1; inValid = 1'b0; cntClr = 1'b0; din0 = '0; din1 = '0;
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_dout",  defDout,   0);
        checkOutput("rst_valid", defValid,  0);
        checkOutput("rst_ovf",   defOvf,    0);
        checkOutput("rst_cnt",   defCnt,    0);
        checkOutput("rst_deep",  deepValid, 0);
        reset = 1'b0;

        $display("[TB] legacy wrap and clamp of 30x40");
        applyStimulus(1, 30, 40);
        applyStimulus(0, 0, 0);
        checkOutput("wrap_dout",  defDout,  -848);
        checkOutput("wrap_valid", defValid, 1);
        checkOutput("wrap_ovf",   defOvf,   1);
        checkOutput("wrap_cnt",   defCnt,   1);
        checkOutput("sat_dout",   satDout,  1023);
        checkOutput("sat_ovf",    satOvf,   1);
        checkOutput("cnt2_first", cntCnt,   1);
        applyStimulus(0, 0, 0);
        checkOutput("idle_valid", defValid, 0);
        checkOutput("idle_ovf",   defOvf,   0);
        checkOutput("idle_cnt",   defCnt,   1);

        $display("[TB] clamp boundaries, back to back");
        applyStimulus(1, -32, 32);
        applyStimulus(1, -32, 33);
        checkOutput("sat_min_dout", satDout, -1024);
        checkOutput("sat_min_ovf",  satOvf,  0);
        checkOutput("wrap_min_dout", defDout, -1024);
        checkOutput("wrap_min_ovf",  defOvf,  0);
        applyStimulus(0, 0, 0);
        checkOutput("sat_under_dout", satDout, -1024);
        checkOutput("sat_under_ovf",  satOvf,  1);
        checkOutput("wrap_under_dout", defDout, 992);
        checkOutput("wrap_under_ovf",  defOvf,  1);
        checkOutput("wrap_under_cnt",  defCnt,  2);

        $display("[TB] fixed-point scaling");
        applyStimulus(1, 3, 5);
        applyStimulus(1, -3, 5);
        checkOutput("rnd_pos", rndDout, 1);
        checkOutput("trn_pos", trnDout, 0);
        checkOutput("rnd_pos_ovf", rndOvf, 0);
        applyStimulus(0, 0, 0);
        checkOutput("rnd_neg", rndDout, -1);
        checkOutput("trn_neg", trnDout, -1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst2_deep_valid", deepValid, 0);

        $display("[TB] four-stage burst with stall");
        applyStimulus(1, 1, 3);
        applyStimulus(1, 2, 3);
        applyStimulus(1, 3, 3);
        checkOutput("deep_latency", deepValid, 0);
        applyStimulus(1, 4, 3);
        checkOutput("deep_b1_dout",  deepDout,  3);
        checkOutput("deep_b1_valid", deepValid, 1);
        ce = 1'b0; inValid = 1'b1; din0 = 11'sd5; din1 = 11'sd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_dout",  deepDout,  3);
            checkOutput("stall_valid", deepValid, 1);
        end
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 0, 5, 3);
            checkOutput("burst_dout",  deepDout,  stallExp[i]);
            checkOutput("burst_valid", deepValid, 1);
        end
        applyStimulus(0, 0, 0);
        checkOutput("burst_end", deepValid, 0);

        $display("[TB] reset with beats in flight");
        applyStimulus(1, 30, 40);
        applyStimulus(1, 30, 40);
        checkOutput("pre_rst_cnt", defCnt, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("flush_valid", defValid,  0);
        checkOutput("flush_dout",  defDout,   0);
        checkOutput("flush_ovf",   defOvf,    0);
        checkOutput("flush_cnt",   defCnt,    0);
        checkOutput("flush_deep_valid", deepValid, 0);
        checkOutput("flush_deep_dout",  deepDout,  0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("dropped_def",  defValid,  0);
            checkOutput("dropped_deep", deepValid, 0);
        end

        $display("[TB] counter saturation and clear");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 30, 40);
        end
        applyStimulus(0, 0, 0);
        checkOutput("cnt2_sat", cntCnt, 3);
        checkOutput("cnt16_5",  defCnt, 5);
        applyStimulus(1, 30, 40);
        cntClr = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("clr_inc_cnt2",  cntCnt, 1);
        checkOutput("clr_inc_cnt16", defCnt, 1);
        cntClr = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("clr_hold", cntCnt, 1);
        ce = 1'b0;
        cntClr = 1'b1;
        tick();
        checkOutput("clr_no_ce_cnt2",  cntCnt, 0);
        checkOutput("clr_no_ce_cnt16", defCnt, 0);
        cntClr = 1'b0;
        ce = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_mul_pipe_rs.md
# sample_mul_pipe_rs

Parametrised pipelined signed multiplier for the sample datapath. It is the next generation of the fixed 11×11 two-stage multiplier and adds configurable operand and result widths, pipeline depth, fixed-point scaling with optional rounding and saturation, valid tracking, and a saturating overflow counter. With default parameters it is bit- and cycle-compatible with the legacy multiplier: truncating, wrapping, 2 stages, `ce`-gated.

## Interface
- `DIN0_WIDTH`, default 11: signed width of operand `din0`.
- `DIN1_WIDTH`, default 11: signed width of operand `din1`.
- `DOUT_WIDTH`, default 11: signed result width.
- `NUM_STAGE`, default 2: pipeline depth in `ce` cycles; must be ≥ 2.
- `FRAC_SHIFT`, default 0: arithmetic right shift applied to the full product; range 0 to DIN0_WIDTH+DIN1_WIDTH-1.
- `ROUND_MODE`, default 0: 0 truncates (floor); 1 rounds half-up.
- `SAT_EN`, default 0: 0 wraps to DOUT_WIDTH; 1 saturates.
- `CNT_WIDTH`, default 16: width of the overflow counter.
- `clk`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `ce`, in, 1: pipeline advance enable.
- `in_valid`, in, 1: qualifies `din0`/`din1`.
- `din0`, in, DIN0_WIDTH: signed operand.
- `din1`, in, DIN1_WIDTH: signed operand.
- `cnt_clr`, in, 1: synchronous clear of `ovf_cnt`.
- `dout`, out, DOUT_WIDTH: signed result.
- `out_valid`, out, 1: `dout` carries a valid beat.
- `ovf`, out, 1: the current valid beat was clamped (SAT_EN=1) or wrapped (SAT_EN=0).
- `ovf_cnt`, out, CNT_WIDTH: saturating count of overflowed beats.

## Operation
- P = din0 × din1, full width DIN0_WIDTH+DIN1_WIDTH, signed.
- Round: if ROUND_MODE=1 and FRAC_SHIFT>0, add 2^(FRAC_SHIFT-1) in a width one bit wider than P, so the maximum positive product cannot overflow.
- Shift: S = (P or P+bias) >>> FRAC_SHIFT, arithmetic shift.
- Saturate (SAT_EN=1): clamp S to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]. Raw overflow = clamp occurred.
- Wrap (SAT_EN=0): take the low DOUT_WIDTH bits of S. Raw overflow = the discarded upper bits are not a sign extension of the kept MSB.
- The data path is not gated by valid. Operands are loaded and multiplied on every `ce`, matching legacy behaviour. The `ovf` register loads raw overflow AND the stage valid, so `ovf`=0 whenever `out_valid`=0.
- `ovf_cnt`:
  - Increments on the edge where the final stage loads a beat with valid=1 and overflow=1.
  - Saturates at 2^CNT_WIDTH-1.
  - `cnt_clr` is honoured regardless of `ce`. If `cnt_clr` and an increment occur in the same cycle, the result is 1.

## Timing
- Stage 1 registers `din0`, `din1`, `in_valid`.
- Stages 2…NUM_STAGE-1 carry the raw product and valid.
- Stage NUM_STAGE registers the rounded/saturated `dout`, `ovf`, `out_valid`. Round/saturate logic is combinational in front of the final register. For NUM_STAGE=2 the multiply is in front of it as well.
- Latency: a beat presented with `ce`=1 at edge k appears at outputs after edge k+NUM_STAGE-1, counting only edges with `ce`=1.
- `ce`=0 freezes every pipeline register, including valid, `dout`, and `ovf`. Outputs hold and no beats are lost or duplicated.
- `reset`=1 at an edge, regardless of `ce`: all valid bits, `dout`, `ovf`, and `ovf_cnt` become 0.
  - In-flight beats are discarded.
  - The first post-reset `out_valid` is no earlier than NUM_STAGE `ce` edges after the first valid input.
- Reset values: `dout`=0, `out_valid`=0, `ovf`=0, `ovf_cnt`=0.
- Back-to-back valid inputs with `ce`=1 give one result per cycle, with no bubbles.

## Structure
- Shared package `sample_mul_pkg` holds:
  - ROUND_TRUNC=0 and ROUND_HALF_UP=1 constants.
  - SAT_WRAP and SAT_CLAMP constants.
  - Functions returning the min/max saturation bounds for a given width.
- One combinational sub-module, `sample_mul_rndsat`, performs bias, shift, and clamp/wrap and produces the raw overflow flag. It is parametrised on input width, DOUT_WIDTH, FRAC_SHIFT, ROUND_MODE, and SAT_EN.
- The top level holds the operand registers, the product delay chain (generate loop), the valid chain, the final register, and the counter.

## Test plan
- Defaults, `ce`=1, din0=30, din1=40, valid → two edges later: `dout`=-848 (1200 wrapped), `out_valid`=1, `ovf`=1, `ovf_cnt`=1.
- SAT_EN=1, 11-bit:
  - 30×40 → `dout`=1023, `ovf`=1.
  - -32×32 → -1024, `ovf`=0.
  - -32×33 → -1024, `ovf`=1.
- FRAC_SHIFT=4:
  - 3×5 gives 1 with ROUND_MODE=1 and 0 with ROUND_MODE=0.
  - -3×5 gives -1 in both modes.
- NUM_STAGE=4, valid burst of 5 beats with `ce` low for 3 cycles mid-burst → 5 results in order, last one 3 cycles later than with no stall, `out_valid` held while stalled.
- `reset` asserted for 1 cycle while 2 beats are in flight → next edge: `out_valid`=0, `dout`=0, `ovf_cnt`=0. Neither dropped beat ever appears.
- CNT_WIDTH=2:
  - 5 overflowing beats → `ovf_cnt`=3 (saturated).
  - `cnt_clr` coincident with an overflow beat → `ovf_cnt`=1.
